// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR tuning controller:
// command bytes, parser states and hex channel decode.
package sdr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CHSEL,
      LOAD
   } state_t;

   localparam logic [7:0] CMD_GAIN0     = 8'h30;
   localparam logic [7:0] CMD_GAIN1     = 8'h31;
   localparam logic [7:0] CMD_GAIN2     = 8'h32;
   localparam logic [7:0] CMD_GAIN3     = 8'h33;
   localparam logic [7:0] CMD_PRE_A     = 8'h61;
   localparam logic [7:0] CMD_PRE_B     = 8'h62;
   localparam logic [7:0] CMD_PRE_F     = 8'h66;
   localparam logic [7:0] CMD_PRE_G     = 8'h67;
   localparam logic [7:0] CMD_UP_COARSE = 8'h6d;
   localparam logic [7:0] CMD_DN_COARSE = 8'h6e;
   localparam logic [7:0] CMD_UP_MID    = 8'h72;
   localparam logic [7:0] CMD_DN_MID    = 8'h71;
   localparam logic [7:0] CMD_UP_FINE   = 8'h70;
   localparam logic [7:0] CMD_DN_FINE   = 8'h6f;
   localparam logic [7:0] CMD_CHSEL     = 8'h63;
   localparam logic [7:0] CMD_LOAD      = 8'h4c;

   // Returns {valid, index} for '0'..'9' and 'A'..'F'.
   function automatic logic [4:0] hex_decode(input logic [7:0] b);
      logic [7:0] d;
      d = 8'h00;
      hex_decode = 5'd0;
      if (b >= 8'h30 && b <= 8'h39) begin
         d = b - 8'h30;
         hex_decode = {1'b1, d[3:0]};
      end else if (b >= 8'h41 && b <= 8'h46) begin
         d = b - 8'h37;
         hex_decode = {1'b1, d[3:0]};
      end
   endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte idle counter; expire stays high once
// LIMIT idle cycles have elapsed since the last load.
module cmd_timeout_counter #(
   parameter int LIMIT = 80000
) (
   input  logic clk,
   input  logic arst_n,
   input  logic load,
   input  logic enable,
   output logic expire
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] count;

   assign expire = (count == W'(LIMIT));

   // Clear on load, count up while enabled, saturate at LIMIT.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable && !expire) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sdr_tune_ctrl.sv
// UART command parser and tuning register file:
// per-channel NCO increments, shared CIC gain, raw loads.
module sdr_tune_ctrl
   import sdr_pkg::*;
#(
   parameter int PHASE_WIDTH    = 64,
   parameter int CHANNELS       = 2,
   parameter int GAIN_WIDTH     = 2,
   parameter int TIMEOUT_CYCLES = 80000,
   parameter logic [PHASE_WIDTH-1:0] STEP_FINE =
      PHASE_WIDTH'(64'h1436a8cdf6f3),
   parameter logic [PHASE_WIDTH-1:0] STEP_MID =
      PHASE_WIDTH'(64'hca22980ba57e),
   parameter logic [PHASE_WIDTH-1:0] STEP_COARSE =
      PHASE_WIDTH'(64'h71b375868d170),
   parameter logic [PHASE_WIDTH-1:0] PRESET_A =
      PHASE_WIDTH'(64'h3dafcea68de1281),
   parameter logic [PHASE_WIDTH-1:0] PRESET_B =
      PHASE_WIDTH'(64'h1aa60f8b8911654),
   parameter logic [PHASE_WIDTH-1:0] PRESET_F =
      PHASE_WIDTH'(64'h1dc38c076704516d),
   parameter logic [PHASE_WIDTH-1:0] PRESET_G =
      PHASE_WIDTH'(64'h1d60d923295482c6),
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic clk,
   input  logic arst_n,
   input  logic rx_valid,
   input  logic [7:0] rx_byte,
   output logic [CHANNELS-1:0][PHASE_WIDTH-1:0] phase_increment,
   output logic [GAIN_WIDTH-1:0] cic_gain,
   output logic [CH_W-1:0] active_channel,
   output logic update_strobe,
   output logic cmd_error,
   output logic [7:0] last_byte
);

   localparam int NBYTES = PHASE_WIDTH / 8;
   localparam int BC_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t state;
   logic [PHASE_WIDTH-1:0] shadow;
   logic [PHASE_WIDTH+7:0] shift;
   logic [PHASE_WIDTH-1:0] cur;
   logic [BC_W-1:0] byte_cnt;
   logic [7:0] gain_raw;
   logic [4:0] hex;
   logic expire;

   cmd_timeout_counter #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk(clk),
      .arst_n(arst_n),
      .load(rx_valid || state == IDLE),
      .enable(state != IDLE),
      .expire(expire)
   );

   // Datapath helpers: current channel value, shifted shadow, decodes.
   always_comb begin
      cur = phase_increment[active_channel];
      shift = {shadow, rx_byte};
      gain_raw = rx_byte - CMD_GAIN0;
      hex = hex_decode(rx_byte);
   end

   // Command FSM with all outputs registered.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= IDLE;
         phase_increment <= '0;
         cic_gain <= '0;
         active_channel <= '0;
         update_strobe <= 1'b0;
         cmd_error <= 1'b0;
         last_byte <= 8'h00;
         shadow <= '0;
         byte_cnt <= '0;
      end else begin
         update_strobe <= 1'b0;
         cmd_error <= 1'b0;
         if (rx_valid) begin
            last_byte <= rx_byte;
         end
         unique case (state)
            IDLE: begin
               if (rx_valid) begin
                  case (rx_byte)
                     CMD_GAIN0, CMD_GAIN1, CMD_GAIN2, CMD_GAIN3: begin
                        cic_gain <= gain_raw[GAIN_WIDTH-1:0];
                        update_strobe <= 1'b1;
                     end
                     CMD_PRE_A: begin
                        phase_increment[active_channel] <= PRESET_A;
                        update_strobe <= 1'b1;
                     end
                     CMD_PRE_B: begin
                        phase_increment[active_channel] <= PRESET_B;
                        update_strobe <= 1'b1;
                     end
                     CMD_PRE_F: begin
                        phase_increment[active_channel] <= PRESET_F;
                        update_strobe <= 1'b1;
                     end
                     CMD_PRE_G: begin
                        phase_increment[active_channel] <= PRESET_G;
                        update_strobe <= 1'b1;
                     end
                     CMD_UP_COARSE: begin
                        phase_increment[active_channel] <= cur + STEP_COARSE;
                        update_strobe <= 1'b1;
                     end
                     CMD_DN_COARSE: begin
                        phase_increment[active_channel] <= cur - STEP_COARSE;
                        update_strobe <= 1'b1;
                     end
                     CMD_UP_MID: begin
                        phase_increment[active_channel] <= cur + STEP_MID;
                        update_strobe <= 1'b1;
                     end
                     CMD_DN_MID: begin
                        phase_increment[active_channel] <= cur - STEP_MID;
                        update_strobe <= 1'b1;
                     end
                     CMD_UP_FINE: begin
                        phase_increment[active_channel] <= cur + STEP_FINE;
                        update_strobe <= 1'b1;
                     end
                     CMD_DN_FINE: begin
                        phase_increment[active_channel] <= cur - STEP_FINE;
                        update_strobe <= 1'b1;
                     end
                     CMD_CHSEL: begin
                        state <= CHSEL;
                     end
                     CMD_LOAD: begin
                        state <= LOAD;
                        shadow <= '0;
                        byte_cnt <= BC_W'(NBYTES - 1);
                     end
                     default: begin
                     end
                  endcase
               end
            end
            CHSEL: begin
               if (rx_valid) begin
                  if (hex[4] && (32'(hex[3:0]) < CHANNELS)) begin
                     active_channel <= CH_W'(hex[3:0]);
                  end else begin
                     cmd_error <= 1'b1;
                  end
                  state <= IDLE;
               end else if (expire) begin
                  cmd_error <= 1'b1;
                  state <= IDLE;
               end
            end
            LOAD: begin
               if (rx_valid) begin
                  if (byte_cnt == '0) begin
                     phase_increment[active_channel] <= shift[PHASE_WIDTH-1:0];
                     update_strobe <= 1'b1;
                     shadow <= '0;
                     state <= IDLE;
                  end else begin
                     shadow <= shift[PHASE_WIDTH-1:0];
                     byte_cnt <= byte_cnt - 1'b1;
                  end
               end else if (expire) begin
                  cmd_error <= 1'b1;
                  shadow <= '0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdr_tune_ctrl.sv
// Scoreboard bench for sdr_tune_ctrl: stimulus pushes expected
// events, a monitor pops them on each strobe or error pulse.
module tb_sdr_tune_ctrl;

   localparam int TO = 64;

   typedef struct packed {
      logic s;
      logic e;
      logic [63:0] c0;
      logic [63:0] c1;
      logic [1:0] g;
      logic a;
   } ev_t;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic rx_valid = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic [1:0][63:0] phase_increment;
   logic [1:0] cic_gain;
   logic [0:0] active_channel;
   logic update_strobe;
   logic cmd_error;
   logic [7:0] last_byte;

   int n_checks = 0;
   int n_err = 0;
   int n_pushed = 0;
   int n_seen = 0;
   ev_t q[$];

   logic [63:0] m_c0 = '0;
   logic [63:0] m_c1 = '0;
   logic [1:0] m_g = '0;
   logic m_a = 1'b0;

   sdr_tune_ctrl #(
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .arst_n(arst_n),
      .rx_valid(rx_valid),
      .rx_byte(rx_byte),
      .phase_increment(phase_increment),
      .cic_gain(cic_gain),
      .active_channel(active_channel),
      .update_strobe(update_strobe),
      .cmd_error(cmd_error),
      .last_byte(last_byte)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic push(input logic s, input logic e);
      ev_t ev;
      ev = '{s: s, e: e, c0: m_c0, c1: m_c1, g: m_g, a: m_a};
      q.push_back(ev);
      n_pushed++;
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_byte = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   // Monitor: compare every strobe/error pulse against the queue head.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (arst_n && (update_strobe || cmd_error)) begin
            n_seen++;
            if (q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_event: got strobe=%b err=%b want none",
                        update_strobe, cmd_error);
            end else begin
               e = q.pop_front();
               chk("ev_strobe", 64'(update_strobe), 64'(e.s));
               chk("ev_error", 64'(cmd_error), 64'(e.e));
               chk("ev_ch0", phase_increment[0], e.c0);
               chk("ev_ch1", phase_increment[1], e.c1);
               chk("ev_gain", 64'(cic_gain), 64'(e.g));
               chk("ev_active", 64'(active_channel), 64'(e.a));
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ch0", phase_increment[0], 64'h0);
      chk("rst_ch1", phase_increment[1], 64'h0);
      chk("rst_gain", 64'(cic_gain), 64'h0);
      chk("rst_flags", {61'h0, active_channel, update_strobe, cmd_error}, 64'h0);
      chk("rst_last", 64'(last_byte), 64'h0);
      arst_n = 1'b1;

      // 1: gain
      m_g = 2'd1;
      push(1'b1, 1'b0);
      send("1");
      chk("t1_ch0", phase_increment[0], 64'h0);

      // 2: preset then fine step up
      m_c0 = 64'h03dafcea68de1281;
      push(1'b1, 1'b0);
      send("a");
      m_c0 = 64'h03db112111ac0974;
      push(1'b1, 1'b0);
      send("p");

      // ignored byte: no event, last_byte follows
      send("z");
      chk("ign_last", 64'(last_byte), 64'h7a);

      // 3: channel 1 raw load
      send("c");
      send("1");
      m_a = 1'b1;
      chk("t3_active", 64'(active_channel), 64'h1);
      send("L");
      for (int i = 1; i <= 7; i++) send(8'(i));
      chk("t3_partial", phase_increment[1], 64'h0);
      m_c1 = 64'h0102030405060708;
      push(1'b1, 1'b0);
      send(8'h08);

      // 4: back to ch0, zero it, bad channel, wrap on fine down
      send("c");
      send("0");
      m_a = 1'b0;
      send("L");
      for (int i = 0; i < 7; i++) send(8'h00);
      m_c0 = 64'h0;
      push(1'b1, 1'b0);
      send(8'h00);
      send("c");
      push(1'b0, 1'b1);
      send("7");
      chk("t4_active", 64'(active_channel), 64'h0);
      m_c0 = 64'hffffebc95732090d;
      push(1'b1, 1'b0);
      send("o");

      // 5: partial load times out
      send("L");
      send(8'haa);
      send(8'hbb);
      push(1'b0, 1'b1);
      send(8'hcc);
      repeat (TO + 10) @(posedge clk);
      m_c0 = 64'h01aa60f8b8911654;
      push(1'b1, 1'b0);
      send("b");

      // 6: async reset mid-load
      send("L");
      send(8'h11);
      send(8'h22);
      @(negedge clk);
      #2;
      arst_n = 1'b0;
      #1;
      chk("t6_ch0", phase_increment[0], 64'h0);
      chk("t6_ch1", phase_increment[1], 64'h0);
      chk("t6_misc", {52'h0, cic_gain, active_channel, update_strobe, last_byte},
          64'h0);
      m_c0 = '0;
      m_c1 = '0;
      m_g = '0;
      m_a = 1'b0;
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      m_g = 2'd2;
      push(1'b1, 1'b0);
      send("2");

      repeat (5) @(posedge clk);
      #1;
      chk("end_queue", 64'(q.size()), 64'h0);
      chk("end_events", 64'(n_seen), 64'(n_pushed));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
